addr_unit: RTL and testbench
============================

Name: addr_unit

Overview:
- Address-generation unit for the CPLD 6502.
- Sits at the receiving end of the Special Bus (SB). When SB_DIR=0 the ALU places its AI operand (0, X, Y, A or M) on SB; this block reads it and forms the 16-bit address bus AB.
- Holds PC and an address-low latch (ADL) and tracks page-crossing carry.
- Drives PCH/PCL back onto the data bus DB for JSR/BRK/IRQ pushes.

Parameters:
- RESET_VEC, 16'hFFFC, address presented on AB during and right after reset.
- IRQ_VEC, 16'hFFFE, base of the IRQ/BRK vector.
- NMI_VEC, 16'hFFFA, base of the NMI vector.

Ports:
- clk  input  1  system clock, all state on rising edge
- RST_N  input  1  synchronous active-low reset
- RDY  input  1  1 = advance; 0 = all registers and outputs hold
- ab_op  input  4  address operation (AB_* codes, shared package)
- vec_sel  input  2  0 = reset, 1 = NMI, 2 = IRQ/BRK; used by AB_VEC
- SB  input  8  special bus, valid when SB_DIR=0 (index or stack pointer)
- DB  inout  8  data bus; read = fetched byte, driven only during AB_PUSHH/AB_PUSHL
- AB  output  16  registered address bus
- PCROSS  output  1  registered; 1 = last indexed add carried out of bit 7

Behaviour:
- Reset (RST_N=0 at a clock edge, regardless of RDY or ab_op) sets:
  - AB = RESET_VEC, PC = 16'h0000, ADL = 0, PCROSS = 0.
  - DB driver off (8'hzz).
  - Reset asserted mid-sequence discards any pending ADL or carry.
- RDY=0: AB, PC, ADL and PCROSS hold. The DB driver keeps its current state.
- All ops below apply on a clock edge with RDY=1. "+" is modulo width.
- AB_HOLD: nothing changes.
- AB_PC: AB <= PC, PC <= PC+1. PC wraps FFFF -> 0000.
- AB_ZP: AB <= {8'h00, DB+SB}. Zero-page wrap: carry discarded, PCROSS <= 0. PC <= PC+1 was done by the preceding AB_PC, so not here.
- AB_ADL: ADL <= DB+SB (low 8 bits); PCROSS <= carry out of bit 7; AB <= PC; PC <= PC+1. This is the absolute-low fetch with index.
- AB_ABS: AB <= {DB+PCROSS, ADL}. Uses the carry latched by AB_ADL, so the page-crossing fix is folded into the same cycle. PCROSS holds, so the controller can add the 6502 penalty cycle.
- AB_ABSNC: AB <= {DB, ADL}; no carry applied. This is the dummy read for the page-cross penalty.
- AB_FIX: AB[15:8] <= AB[15:8]+1 and AB[7:0] holds; PCROSS <= 0.
- AB_STACK: AB <= {8'h01, SB}. SB carries S from the ALU side.
- AB_JMP: PC <= {DB, ADL}+1 and AB <= {DB, ADL}. Fetch continues at the target.
- AB_VEC:
  - AB <= base(vec_sel). Base: sel 0 = RESET_VEC, 1 = NMI_VEC, 2 or 3 = IRQ_VEC.
  - Next AB_VECH: AB[0] <= 1.
  - ADL <= DB on the AB_VECH edge, then AB_JMP completes the vector load.
- AB_PUSHH: DB <= PC[15:8], driven for exactly this cycle; AB <= {01, SB}.
- AB_PUSHL: DB <= PC[7:0]; AB <= {01, SB}.
- Driver timing: the driver enables combinationally from the registered push flag. It releases on the first edge with a non-push op.
- Simultaneous events:
  - The carry from AB_ADL and an AB_FIX on the same edge is impossible by construction: op is one-hot in time.
  - Undefined ab_op codes behave as AB_HOLD.
- Latency: AB is valid one clock after the op. PCROSS is valid one clock after AB_ADL.

Decomposition:
- Shared package (states.i additions): AB_HOLD=0, AB_PC=1, AB_ZP=2, AB_ADL=3, AB_ABS=4, AB_ABSNC=5, AB_FIX=6, AB_STACK=7, AB_JMP=8, AB_VEC=9, AB_VECH=10, AB_PUSHH=11, AB_PUSHL=12. Vector select constants VEC_RST, VEC_NMI, VEC_IRQ.
- One natural sub-module, pc_reg:
  - 16-bit PC with load and increment.
  - Enable = RDY.
  - Synchronous active-low reset.

Test Plan:
- Reset: RST_N=0 for 2 clocks with ab_op=AB_PC -> AB=FFFC, PC=0000, PCROSS=0, DB=zz. Then AB_VEC sel 0, AB_VECH with DB=34, AB_JMP with DB=12 -> AB=1234 and PC=1235.
- Zero-page wrap: DB=F0, SB=20, AB_ZP -> AB=0010, PCROSS=0.
- Absolute indexed with page cross:
  - AB_ADL with DB=F0, SB=20 -> ADL=10, PCROSS=1.
  - AB_ABS with DB=12 -> AB=1310.
  - Without cross (DB=10, SB=05) -> AB=1215, PCROSS=0.
- Push PC: PC=ABCD, SB=FD, AB_PUSHH -> AB=01FD, DB=AB. SB=FC, AB_PUSHL -> DB=CD. AB_HOLD -> DB=zz.
- RDY stall: mid AB_ADL/AB_ABS sequence, RDY=0 for 3 clocks with changing DB/SB -> AB, PC, ADL and PCROSS unchanged; the sequence resumes correctly on RDY=1.
- PC wrap: PC=FFFF, AB_PC -> AB=FFFF, PC=0000. Reset asserted during AB_PUSHH -> DB released next edge, AB=FFFC.

Source files
------------

// File: rtl/addr_unit_pkg.sv
// Shared address-operation codes and vector helpers for the 6502 address unit.
package addr_unit_pkg;

    typedef enum logic [3:0] {
        AB_HOLD  = 4'd0,
        AB_PC    = 4'd1,
        AB_ZP    = 4'd2,
        AB_ADL   = 4'd3,
        AB_ABS   = 4'd4,
        AB_ABSNC = 4'd5,
        AB_FIX   = 4'd6,
        AB_STACK = 4'd7,
        AB_JMP   = 4'd8,
        AB_VEC   = 4'd9,
        AB_VECH  = 4'd10,
        AB_PUSHH = 4'd11,
        AB_PUSHL = 4'd12
    } ab_op_e;

    localparam logic [1:0] VEC_RST = 2'd0;
    localparam logic [1:0] VEC_NMI = 2'd1;
    localparam logic [1:0] VEC_IRQ = 2'd2;

    // Select 3 aliases IRQ/BRK so every encoding maps to a real vector.
    function automatic logic [15:0] vec_base(input logic [1:0]  sel,
                                             input logic [15:0] rst_v,
                                             input logic [15:0] nmi_v,
                                             input logic [15:0] irq_v);
        logic [15:0] base;
        case (sel)
            VEC_RST: base = rst_v;
            VEC_NMI: base = nmi_v;
            default: base = irq_v;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/addr_unit_if.sv
// Controller-to-address-unit bus: op code, vector select, SB operand, AB and page-cross flag.
interface addr_unit_if;
    logic [3:0]  ab_op;
    logic [1:0]  vec_sel;
    logic [7:0]  SB;
    logic [15:0] AB;
    logic        PCROSS;

    modport master (output ab_op, output vec_sel, output SB, input AB, input PCROSS);
    modport slave  (input ab_op, input vec_sel, input SB, output AB, output PCROSS);
endinterface

// File: rtl/addr_unit_pc_reg.sv
// 16-bit program counter with load and increment, gated by RDY.
module addr_unit_pc_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic [15:0] pc
);
    logic [15:0] pc_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg <= 16'h0000;
        end else if (en) begin
            if (load)
                pc_reg <= load_val;
            else if (inc)
                pc_reg <= pc_reg + 16'd1;
        end
    end

    assign pc = pc_reg;
endmodule

// File: rtl/addr_unit.sv
// Address-generation unit: forms AB from PC, SB and fetched bytes, tracks page crossing,
// and pushes PCH/PCL onto DB.
module addr_unit
    import addr_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC   = 16'hFFFE,
    parameter logic [15:0] NMI_VEC   = 16'hFFFA
) (
    input  logic           clk,
    input  logic           RST_N,
    input  logic           RDY,
    addr_unit_if.slave     bus,
    inout  wire  [7:0]     DB
);
    logic [15:0] ab_reg, ab_next;
    logic [7:0]  adl_reg, adl_next;
    logic        pcross_reg, pcross_next;
    logic        push_reg, push_next;
    logic [7:0]  db_out_reg, db_out_next;

    logic [15:0] pc;
    logic        pc_load, pc_inc;
    logic [7:0]  db_in;
    logic [8:0]  idx_sum;
    logic [15:0] jmp_tgt;

    assign db_in   = DB;
    assign idx_sum = {1'b0, db_in} + {1'b0, bus.SB};
    assign jmp_tgt = {db_in, adl_reg};

    addr_unit_pc_reg u_pc (
        .clk      (clk),
        .rst_n    (RST_N),
        .en       (RDY),
        .load     (pc_load),
        .load_val (jmp_tgt + 16'd1),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_comb begin
        ab_next     = ab_reg;
        adl_next    = adl_reg;
        pcross_next = pcross_reg;
        push_next   = 1'b0;
        db_out_next = db_out_reg;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        case (bus.ab_op)
            AB_PC: begin
                ab_next = pc;
                pc_inc  = 1'b1;
            end
            AB_ZP: begin
                ab_next     = {8'h00, idx_sum[7:0]};
                pcross_next = 1'b0;
            end
            AB_ADL: begin
                adl_next    = idx_sum[7:0];
                pcross_next = idx_sum[8];
                ab_next     = pc;
                pc_inc      = 1'b1;
            end
            // The latched carry is folded into the high byte in the same cycle.
            AB_ABS:   ab_next = {db_in + {7'd0, pcross_reg}, adl_reg};
            AB_ABSNC: ab_next = {db_in, adl_reg};
            AB_FIX: begin
                ab_next     = {ab_reg[15:8] + 8'd1, ab_reg[7:0]};
                pcross_next = 1'b0;
            end
            AB_STACK: ab_next = {8'h01, bus.SB};
            AB_JMP: begin
                ab_next = jmp_tgt;
                pc_load = 1'b1;
            end
            AB_VEC:   ab_next = vec_base(bus.vec_sel, RESET_VEC, NMI_VEC, IRQ_VEC);
            AB_VECH: begin
                ab_next  = {ab_reg[15:1], 1'b1};
                adl_next = db_in;
            end
            AB_PUSHH: begin
                ab_next     = {8'h01, bus.SB};
                push_next   = 1'b1;
                db_out_next = pc[15:8];
            end
            AB_PUSHL: begin
                ab_next     = {8'h01, bus.SB};
                push_next   = 1'b1;
                db_out_next = pc[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            ab_reg     <= RESET_VEC;
            adl_reg    <= 8'h00;
            pcross_reg <= 1'b0;
            push_reg   <= 1'b0;
            db_out_reg <= 8'h00;
        end else if (RDY) begin
            ab_reg     <= ab_next;
            adl_reg    <= adl_next;
            pcross_reg <= pcross_next;
            push_reg   <= push_next;
            db_out_reg <= db_out_next;
        end
    end

    assign bus.AB     = ab_reg;
    assign bus.PCROSS = pcross_reg;
    assign DB         = push_reg ? db_out_reg : 8'hzz;
endmodule

// File: tb/tb_addr_unit.sv
// Randomised bench for addr_unit against an arithmetic reference model of the address rules.
module tb_addr_unit;
    import addr_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b1;
    logic [7:0] db_drv = 8'h00;
    logic       db_tb_oe = 1'b1;
    wire  [7:0] DB;

    addr_unit_if bus ();

    assign DB = db_tb_oe ? db_drv : 8'hzz;

    addr_unit dut (
        .clk   (clk),
        .RST_N (rst_n),
        .RDY   (rdy),
        .bus   (bus),
        .DB    (DB)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state, kept as plain integers.
    int m_ab     = 16'hFFFC;
    int m_pc     = 0;
    int m_adl    = 0;
    int m_pcross = 0;
    int m_drive  = 0;
    int m_dbval  = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input int op, input int vs, input int din, input int sb,
                         input bit rd, input bit rst);
        int sum;
        int drv_new;
        if (!rst) begin
            m_ab = 16'hFFFC; m_pc = 0; m_adl = 0; m_pcross = 0; m_drive = 0;
        end else if (rd) begin
            sum = din + sb;
            drv_new = 0;
            case (op)
                1:  begin m_ab = m_pc; m_pc = (m_pc + 1) % 65536; end
                2:  begin m_ab = sum % 256; m_pcross = 0; end
                3:  begin m_adl = sum % 256; m_pcross = sum / 256; m_ab = m_pc; m_pc = (m_pc + 1) % 65536; end
                4:  m_ab = ((din + m_pcross) % 256) * 256 + m_adl;
                5:  m_ab = din * 256 + m_adl;
                6:  begin m_ab = (((m_ab / 256) + 1) % 256) * 256 + (m_ab % 256); m_pcross = 0; end
                7:  m_ab = 256 + sb;
                8:  begin m_ab = din * 256 + m_adl; m_pc = (m_ab + 1) % 65536; end
                9:  m_ab = (vs == 0) ? 16'hFFFC : (vs == 1) ? 16'hFFFA : 16'hFFFE;
                10: begin m_ab = m_ab | 1; m_adl = din; end
                11: begin m_ab = 256 + sb; m_dbval = m_pc / 256; drv_new = 1; end
                12: begin m_ab = 256 + sb; m_dbval = m_pc % 256; drv_new = 1; end
                default: ;
            endcase
            m_drive = drv_new;
        end
    endtask

    // One clock: apply inputs, advance model, then compare AB, PCROSS and DB.
    task automatic step(input logic [3:0] op, input logic [1:0] vs, input logic [7:0] db,
                        input logic [7:0] sb, input logic rd, input logic rst);
        int din;
        bus.ab_op   = op;
        bus.vec_sel = vs;
        bus.SB      = sb;
        db_drv      = db;
        rdy         = rd;
        rst_n       = rst;
        din = (m_drive != 0) ? m_dbval : int'(db);
        @(posedge clk);
        #1;
        model(int'(op), int'(vs), din, int'(sb), rd, rst);
        db_tb_oe = (m_drive == 0);
        #1;
        check_val("AB", bus.AB, 16'(m_ab));
        check_val("PCROSS", {15'd0, bus.PCROSS}, 16'(m_pcross));
        check_val("DB", {8'h00, DB}, (m_drive != 0) ? 16'(m_dbval) : {8'h00, db_drv});
        $display("op=%0d rst_n=%0b rdy=%0b db=%h sb=%h -> AB=%h PCROSS=%0b DB=%h",
                 op, rst, rd, db, sb, bus.AB, bus.PCROSS, DB);
    endtask

    initial begin
        bus.ab_op = AB_HOLD; bus.vec_sel = 2'd0; bus.SB = 8'h00;

        // Reset for two clocks with AB_PC pending.
        step(AB_PC, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(AB_PC, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("rst_ab", bus.AB, 16'hFFFC);
        check_val("rst_pcross", {15'd0, bus.PCROSS}, 16'h0000);

        // Reset vector load.
        step(AB_VEC,  VEC_RST, 8'h00, 8'h00, 1'b1, 1'b1);
        check_val("vec_ab", bus.AB, 16'hFFFC);
        step(AB_VECH, 2'd0, 8'h34, 8'h00, 1'b1, 1'b1);
        check_val("vech_ab", bus.AB, 16'hFFFD);
        step(AB_JMP,  2'd0, 8'h12, 8'h00, 1'b1, 1'b1);
        check_val("jmp_ab", bus.AB, 16'h1234);
        step(AB_PC,   2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        check_val("jmp_pc", bus.AB, 16'h1235);

        // Zero-page wrap.
        step(AB_ZP, 2'd0, 8'hF0, 8'h20, 1'b1, 1'b1);
        check_val("zp_ab", bus.AB, 16'h0010);
        check_val("zp_pcross", {15'd0, bus.PCROSS}, 16'h0000);

        // Indexed absolute with page cross and an RDY stall in the middle.
        step(AB_ADL, 2'd0, 8'hF0, 8'h20, 1'b1, 1'b1);
        check_val("adl_pcross", {15'd0, bus.PCROSS}, 16'h0001);
        check_val("adl_ab", bus.AB, 16'h1236);
        for (int i = 0; i < 3; i++)
            step(AB_ABS, 2'd0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        check_val("stall_ab", bus.AB, 16'h1236);
        check_val("stall_pcross", {15'd0, bus.PCROSS}, 16'h0001);
        step(AB_ABS, 2'd0, 8'h12, 8'h00, 1'b1, 1'b1);
        check_val("abs_cross_ab", bus.AB, 16'h1310);
        check_val("abs_pcross_hold", {15'd0, bus.PCROSS}, 16'h0001);
        step(AB_ADL, 2'd0, 8'h10, 8'h05, 1'b1, 1'b1);
        check_val("adl_nc_pcross", {15'd0, bus.PCROSS}, 16'h0000);
        step(AB_ABS, 2'd0, 8'h12, 8'h00, 1'b1, 1'b1);
        check_val("abs_nc_ab", bus.AB, 16'h1215);

        // Push PC = ABCD.
        step(AB_VECH, 2'd0, 8'hCC, 8'h00, 1'b1, 1'b1);
        step(AB_JMP,  2'd0, 8'hAB, 8'h00, 1'b1, 1'b1);
        step(AB_PUSHH, 2'd0, 8'h00, 8'hFD, 1'b1, 1'b1);
        check_val("pushh_ab", bus.AB, 16'h01FD);
        check_val("pushh_db", {8'h00, DB}, 16'h00AB);
        step(AB_PUSHL, 2'd0, 8'h00, 8'hFC, 1'b1, 1'b1);
        check_val("pushl_db", {8'h00, DB}, 16'h00CD);
        step(AB_HOLD, 2'd0, 8'h5A, 8'h00, 1'b1, 1'b1);
        check_val("release_db", {8'h00, DB}, 16'h005A);

        // PC wrap.
        step(AB_VECH, 2'd0, 8'hFE, 8'h00, 1'b1, 1'b1);
        step(AB_JMP,  2'd0, 8'hFF, 8'h00, 1'b1, 1'b1);
        step(AB_PC,   2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        check_val("wrap_ab", bus.AB, 16'hFFFF);
        step(AB_PC,   2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        check_val("wrap_pc", bus.AB, 16'h0000);

        // Reset during a push.
        step(AB_PUSHH, 2'd0, 8'h00, 8'hF0, 1'b1, 1'b1);
        step(AB_PUSHH, 2'd0, 8'h77, 8'hEF, 1'b1, 1'b0);
        check_val("rst_push_ab", bus.AB, 16'hFFFC);
        check_val("rst_push_db", {8'h00, DB}, 16'h0077);

        // Random traffic, including undefined op codes, stalls and occasional resets.
        for (int i = 0; i < 1500; i++)
            step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 63) != 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
